// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue 32-bit ALU with a valid/ready handshake on
// both sides. Non-shift ops finish one cycle after acceptance. Shifts move
// one bit per cycle through the result register.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_valid / in_ready  operation handshake (in_ready is combinational)
//   ALUCtrl, Sign, A, B  operation code, signedness and operands
//                        (shifts: A[4:0] = amount, B = value)
//   out_valid/out_ready  result handshake
//   Result, Zero, Overflow  registered result outputs
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  ALUCtrl,
    input  logic        Sign,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Overflow
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 5;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_XOR = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] OP_NOR = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_SLL = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_SRL = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_SRA = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] OP_LUI = CTRL_W'(10);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_e;

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 overflow_q, overflow_d;
    logic                 out_valid_q, out_valid_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    shift_kind_e          shift_kind_q, shift_kind_d;

    logic                 accept_c;
    logic                 is_shift_c;
    state_e               start_state_c;
    logic [DATA_W-1:0]    alu_res_c;
    logic                 alu_ovf_c;
    shift_kind_e          kind_c;
    logic [DATA_W-1:0]    shifted_c;
    logic [DATA_W-1:0]    sum_c;
    logic [DATA_W-1:0]    diff_c;
    logic                 slt_c;

    // Accept in IDLE, or in DONE while the consumer drains the current result.
    always_comb begin
        in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        accept_c = in_valid && in_ready;
    end

    // Combinational ALU evaluated on the presented operands.
    always_comb begin
        sum_c     = A + B;
        diff_c    = A - B;
        slt_c     = Sign ? ($signed(A) < $signed(B)) : (A < B);
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        kind_c    = SK_SLL;
        unique case (ALUCtrl)
            OP_ADD: begin
                alu_res_c = sum_c;
                // Same-sign operands producing a result of the other sign.
                alu_ovf_c = Sign && (A[DATA_W-1] == B[DATA_W-1])
                                 && (sum_c[DATA_W-1] != A[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = Sign && (A[DATA_W-1] != B[DATA_W-1])
                                 && (diff_c[DATA_W-1] != A[DATA_W-1]);
            end
            OP_AND: alu_res_c = A & B;
            OP_OR:  alu_res_c = A | B;
            OP_XOR: alu_res_c = A ^ B;
            OP_NOR: alu_res_c = ~(A | B);
            // Shifts load the unshifted value; the SHIFT state does the work.
            OP_SLL: begin alu_res_c = B; kind_c = SK_SLL; end
            OP_SRL: begin alu_res_c = B; kind_c = SK_SRL; end
            OP_SRA: begin alu_res_c = B; kind_c = SK_SRA; end
            OP_SLT: alu_res_c = DATA_W'(slt_c);
            OP_LUI: alu_res_c = {B[15:0], 16'h0000};
            default: begin
                alu_res_c = '0;
                alu_ovf_c = 1'b0;
            end
        endcase
        is_shift_c    = (ALUCtrl == OP_SLL) || (ALUCtrl == OP_SRL) || (ALUCtrl == OP_SRA);
        start_state_c = (is_shift_c && (A[SHAMT_W-1:0] != '0)) ? S_SHIFT : S_DONE;
    end

    // One-bit shift step on the held value.
    always_comb begin
        unique case (shift_kind_q)
            SK_SRL:  shifted_c = {1'b0, result_q[DATA_W-1:1]};
            SK_SRA:  shifted_c = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
            default: shifted_c = {result_q[DATA_W-2:0], 1'b0};
        endcase
    end

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            result_q     <= '0;
            zero_q       <= 1'b0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            count_q      <= '0;
            shift_kind_q <= SK_SLL;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            count_q      <= count_d;
            shift_kind_q <= shift_kind_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid) state_d = start_state_c;
            S_SHIFT: if (count_q == SHAMT_W'(1)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = in_valid ? start_state_c : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        result_d     = result_q;
        zero_d       = zero_q;
        overflow_d   = overflow_q;
        count_d      = count_q;
        shift_kind_d = shift_kind_q;
        out_valid_d  = (state_d == S_DONE);
        if (accept_c) begin
            result_d     = alu_res_c;
            zero_d       = (alu_res_c == '0);
            overflow_d   = alu_ovf_c;
            count_d      = A[SHAMT_W-1:0];
            shift_kind_d = kind_c;
        end else if (state_q == S_SHIFT) begin
            result_d = shifted_c;
            zero_d   = (shifted_c == '0);
            count_d  = count_q - SHAMT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALUCtrl;
    logic        Sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;

    int checks = 0;
    int errors = 0;

    alu_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUCtrl   (ALUCtrl),
        .Sign      (Sign),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on wide integers.
    function automatic void ref_alu(input logic [4:0] c, input logic s,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o);
        longint sa;
        longint sb;
        longint ws;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        o  = 1'b0;
        case (c)
            5'd0: begin
                r  = a + b;
                ws = sa + sb;
                o  = s && (ws > 64'sd2147483647 || ws < -64'sd2147483648);
            end
            5'd1: begin
                r  = a - b;
                ws = sa - sb;
                o  = s && (ws > 64'sd2147483647 || ws < -64'sd2147483648);
            end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~(a | b);
            5'd6:  r = b << a[4:0];
            5'd7:  r = b >> a[4:0];
            5'd8:  r = $signed(b) >>> a[4:0];
            5'd9:  r = s ? 32'(sa < sb) : 32'(longint'(a) < longint'(b));
            5'd10: r = {b[15:0], 16'h0000};
            default: begin r = 32'h0; o = 1'b0; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] c, input logic [31:0] a);
        if (c >= 5'd6 && c <= 5'd8 && a[4:0] != 5'd0) return int'(a[4:0]) + 1;
        return 1;
    endfunction

    // Issues one op from IDLE, waits for it, checks it, then drains it.
    task automatic exec_and_check(input logic [4:0] c, input logic s,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input string name);
        logic [31:0] er;
        logic        eo;
        int          el;
        int          cyc;
        ref_alu(c, s, a, b, er, eo);
        el = ref_latency(c, a);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_in_ready got %b want 1", name, in_ready);
        end
        in_valid = 1'b1; ALUCtrl = c; Sign = s; A = a; B = b; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; A = $urandom; B = $urandom; ALUCtrl = 5'($urandom);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_in_ready cycle %0d got %b want 0", name, cyc, in_ready);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1 || cyc != el) begin
            errors++;
            $display("FAIL %s latency got %0d (valid %b) want %0d", name, cyc, out_valid, el);
        end
        checks++;
        if (Result !== er || Overflow !== eo || Zero !== (er == 32'h0)) begin
            errors++;
            $display("FAIL %s result got %h ovf %b zero %b want %h ovf %b zero %b",
                     name, Result, Overflow, Zero, er, eo, (er == 32'h0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s drain_out_valid got %b want 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUCtrl = 5'd0; Sign = 1'b0; A = 32'h0; B = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || Result !== 32'h0 || Zero !== 1'b0 ||
            Overflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got valid %b res %h zero %b ovf %b rdy %b want 0 0 0 0 1",
                     out_valid, Result, Zero, Overflow, in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        exec_and_check(5'd0, 1'b1, 32'h7FFF_FFFF, 32'h1, "add_signed_ovf");
        exec_and_check(5'd0, 1'b0, 32'h7FFF_FFFF, 32'h1, "add_unsigned");
        exec_and_check(5'd1, 1'b1, 32'h8000_0000, 32'h1, "sub_signed_ovf");
        exec_and_check(5'd1, 1'b1, 32'h1234_5678, 32'h1234_5678, "sub_zero");
        exec_and_check(5'd9, 1'b1, 32'hFFFF_FFFF, 32'h1, "slt_signed");
        exec_and_check(5'd9, 1'b0, 32'hFFFF_FFFF, 32'h1, "slt_unsigned");
        exec_and_check(5'd8, 1'b0, 32'h4, 32'h8000_0000, "sra_4");
        exec_and_check(5'd6, 1'b0, 32'h0, 32'hDEAD_BEEF, "sll_0");
        exec_and_check(5'd6, 1'b0, 32'h1F, 32'h0000_0003, "sll_31");
        exec_and_check(5'd7, 1'b0, 32'h1, 32'h8000_0001, "srl_1");
        exec_and_check(5'd15, 1'b1, 32'h7FFF_FFFF, 32'h1, "undef_15");
        exec_and_check(5'd10, 1'b0, 32'h0, 32'h0000_ABCD, "lui");
        exec_and_check(5'd5, 1'b0, 32'hFFFF_0000, 32'h0000_FFFF, "nor_zero");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; ALUCtrl = 5'd0; Sign = 1'b0; A = 32'd5; B = 32'd7; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || Result !== 32'd12 || Zero !== 1'b0 ||
                Overflow !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %b res %h zero %b ovf %b rdy %b want 1 0000000c 0 0 0",
                         i, out_valid, Result, Zero, Overflow, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1; ALUCtrl = 5'd0; A = 32'd1; B = 32'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_b2b_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Result !== 32'd3 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_b2b_result got valid %b res %h zero %b want 1 00000003 0",
                     out_valid, Result, Zero);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int stale;
        @(negedge clk);
        in_valid = 1'b1; ALUCtrl = 5'd7; Sign = 1'b0; A = 32'd31; B = 32'hFFFF_FFFF; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || Result !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_shift got valid %b res %h rdy %b want 0 00000000 1",
                     out_valid, Result, in_ready);
        end
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL reset_no_stale got %0d valid cycles want 0", stale);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0]  c;
        logic [31:0] a;
        for (int i = 0; i < 150; i++) begin
            c = (i % 4 == 0) ? 5'($urandom_range(6, 8)) : 5'($urandom);
            a = $urandom;
            if (c >= 5'd6 && c <= 5'd8) a[4:0] = 5'($urandom_range(0, 12));
            exec_and_check(c, 1'($urandom), a, $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  c, nc;
        logic        s, ns;
        logic [31:0] a, b, na, nb, er;
        logic        eo;
        int          el, cyc;
        c = 5'($urandom_range(0, 11)); s = 1'($urandom); a = $urandom & 32'hF; b = $urandom;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; ALUCtrl = c; Sign = s; A = a; B = b;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ref_alu(c, s, a, b, er, eo);
            el = ref_latency(c, a);
            cyc = 1;
            while (out_valid !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (out_valid !== 1'b1 || cyc != el) begin
                errors++;
                $display("FAIL b2b_latency op %0d got %0d want %0d", i, cyc, el);
            end
            checks++;
            if (Result !== er || Overflow !== eo || Zero !== (er == 32'h0) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_result op %0d got %h ovf %b zero %b rdy %b want %h ovf %b zero %b rdy 1",
                         i, Result, Overflow, Zero, in_ready, er, eo, (er == 32'h0));
            end
            nc = 5'($urandom_range(0, 11)); ns = 1'($urandom); na = $urandom & 32'hF; nb = $urandom;
            in_valid = (i < 39); ALUCtrl = nc; Sign = ns; A = na; B = nb;
            @(negedge clk);
            in_valid = 1'b0;
            c = nc; s = ns; a = na; b = nb;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_idle got %b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
